// File: rtl/cordic_table_loader.sv
// Byte-serial loader for the CORDIC/DDS coefficient table.
// Optional trailing XOR checksum byte: define CHECKSUM_EN.
module cordic_table_loader #(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6,
  parameter int DATA_W  = 48
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_tbl_we,
  output logic [IDX_W-1:0]  o_index_wri,
  output logic [DATA_W-1:0] o_D,
  output logic              o_cen,
  output logic              o_done,
  output logic              o_err
);

  localparam int BPE  = DATA_W / 8;
  localparam int BC_W = $clog2(BPE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHK,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [BC_W-1:0]     r_bcnt;
  logic [IDX_W-1:0]    r_idx;
  logic                r_in_ready;
  logic                r_tbl_we;
  logic [IDX_W-1:0]    r_index_wri;
  logic [DATA_W-1:0]   r_d;
  logic                r_cen;
  logic                r_done;
  logic                r_err;
`ifdef CHECKSUM_EN
  logic [7:0]          r_xor;
`endif

  logic w_xfer;
  logic w_last_byte;
  logic w_last_ent;

  assign w_xfer      = i_in_valid & r_in_ready & ~i_abort;
  assign w_last_byte = (r_bcnt == BC_W'(BPE - 1));
  assign w_last_ent  = (r_idx == IDX_W'(ENTRIES - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_tbl_we    <= 1'b0;
      r_index_wri <= '0;
      r_d         <= '0;
      r_cen       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_tbl_we <= 1'b0;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_err      <= 1'b0;
            r_cen      <= 1'b0;
            r_in_ready <= 1'b1;
`ifdef CHECKSUM_EN
            r_xor      <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_in_ready <= 1'b0;
          end else if (w_xfer) begin
            r_d <= {r_d[DATA_W-9:0], i_in_data};
`ifdef CHECKSUM_EN
            r_xor <= r_xor ^ i_in_data;
`endif
            if (w_last_byte) begin
              r_bcnt      <= '0;
              r_tbl_we    <= 1'b1;
              r_index_wri <= r_idx;
              r_idx       <= r_idx + 1'b1;
              // Final entry: stop taking payload once it is packed
              if (w_last_ent) begin
`ifdef CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
`endif
              end
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
        end
`ifdef CHECKSUM_EN
        S_CHK: begin
          if (i_abort) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_in_ready <= 1'b0;
          end else if (w_xfer) begin
            r_in_ready <= 1'b0;
            if (i_in_data == r_xor) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          r_done  <= 1'b1;
          r_cen   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_tbl_we    = r_tbl_we;
  assign o_index_wri = r_index_wri;
  assign o_D         = r_d;
  assign o_cen       = r_cen;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
